// File: rtl/key_len_seq_ctrl_if.sv
// Handshake bundle between the key-length sequencer and its estimators and l datapath.
// The controller uses the master view; the surrounding environment uses the slave view.
interface key_len_seq_ctrl_if;
  logic        i_start;
  logic [31:0] i_nleak;
  logic        o_s1_start;
  logic        o_e1_start;
  logic [31:0] i_s1;
  logic        i_s1_vld;
  logic [31:0] i_e1;
  logic        i_e1_vld;
  logic        o_l_start;
  logic [31:0] o_l_s1;
  logic        o_l_s1_vld;
  logic [31:0] o_l_e1;
  logic        o_l_e1_vld;
  logic [31:0] o_l_nleak;
  logic [31:0] i_l;
  logic        i_l_vld;
  logic        i_l_error;
  logic        o_busy;
  logic [31:0] o_key_len;
  logic        o_key_len_vld;
  logic        o_err;
  logic [1:0]  o_err_code;

  modport master (
    input  i_start, i_nleak, i_s1, i_s1_vld, i_e1, i_e1_vld, i_l, i_l_vld, i_l_error,
    output o_s1_start, o_e1_start, o_l_start, o_l_s1, o_l_s1_vld, o_l_e1, o_l_e1_vld,
           o_l_nleak, o_busy, o_key_len, o_key_len_vld, o_err, o_err_code
  );

  modport slave (
    output i_start, i_nleak, i_s1, i_s1_vld, i_e1, i_e1_vld, i_l, i_l_vld, i_l_error,
    input  o_s1_start, o_e1_start, o_l_start, o_l_s1, o_l_s1_vld, o_l_e1, o_l_e1_vld,
           o_l_nleak, o_busy, o_key_len, o_key_len_vld, o_err, o_err_code
  );
endinterface

// File: rtl/key_len_seq_ctrl.sv
// Final key-length sequencer: launches s1/e1 estimators, range-checks e1, drives the
// l datapath handshake and reports the key length or a coded error, under a timeout.
module key_len_seq_ctrl #(
  parameter int unsigned E1_AMP  = 24,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 13
) (
  input logic          clk,
  input logic          rst,
  key_len_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, CALC, CHECK, LAUNCH, FEED, WAIT_L, DONE, ERR
  } state_t;

  state_t           state, state_d;
  logic [31:0]      s1_q, e1_q, nleak_q, key_len_q;
  logic             s1_seen, e1_seen, s1_seen_d, e1_seen_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       err_code_q, err_code_d;
  logic             est_start_q, l_start_q, l_vld_q, key_len_vld_q, err_q, busy_q;
  logic             accept, timeout, e1_ok;

  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));
  // e1 must be a nonzero fraction strictly below 1.0 in its amplified fixed-point form
  assign e1_ok   = (e1_q != '0) && ((e1_q >> E1_AMP) == '0);

  always_comb begin
    state_d    = state;
    err_code_d = err_code_q;
    accept     = 1'b0;
    s1_seen_d  = s1_seen | bus.i_s1_vld;
    e1_seen_d  = e1_seen | bus.i_e1_vld;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          accept     = 1'b1;
          err_code_d = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (s1_seen_d && e1_seen_d) begin
          state_d = CHECK;
        end else if (timeout) begin
          state_d    = ERR;
          err_code_d = 2'd3;
        end
      end
      CHECK: begin
        if (e1_ok) begin
          state_d = LAUNCH;
        end else begin
          state_d    = ERR;
          err_code_d = 2'd1;
        end
      end
      LAUNCH: state_d = FEED;
      FEED:   state_d = WAIT_L;
      WAIT_L: begin
        if (bus.i_l_vld) begin
          if (bus.i_l_error) begin
            state_d    = ERR;
            err_code_d = 2'd2;
          end else begin
            state_d = DONE;
          end
        end else if (timeout) begin
          state_d    = ERR;
          err_code_d = 2'd3;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse coincides with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s1_q          <= '0;
      e1_q          <= '0;
      nleak_q       <= '0;
      key_len_q     <= '0;
      s1_seen       <= 1'b0;
      e1_seen       <= 1'b0;
      cnt           <= '0;
      err_code_q    <= '0;
      est_start_q   <= 1'b0;
      l_start_q     <= 1'b0;
      l_vld_q       <= 1'b0;
      key_len_vld_q <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_d;
      err_code_q    <= err_code_d;
      est_start_q   <= accept;
      l_start_q     <= (state_d == LAUNCH);
      l_vld_q       <= (state_d == FEED);
      key_len_vld_q <= (state_d == DONE);
      err_q         <= (state_d == ERR);
      busy_q        <= (state_d != IDLE);
      if (accept) begin
        nleak_q <= bus.i_nleak;
        s1_seen <= 1'b0;
        e1_seen <= 1'b0;
      end
      if (state == CALC) begin
        if (bus.i_s1_vld && !s1_seen) begin
          s1_q    <= bus.i_s1;
          s1_seen <= 1'b1;
        end
        if (bus.i_e1_vld && !e1_seen) begin
          e1_q    <= bus.i_e1;
          e1_seen <= 1'b1;
        end
      end
      if (state_d == DONE) begin
        key_len_q <= bus.i_l[31] ? '0 : bus.i_l;
      end
      if ((state_d == CALC) || (state_d == WAIT_L)) begin
        cnt <= (state_d == state) ? cnt + CNT_W'(1) : '0;
      end
    end
  end

  assign bus.o_s1_start    = est_start_q;
  assign bus.o_e1_start    = est_start_q;
  assign bus.o_l_start     = l_start_q;
  assign bus.o_l_s1        = s1_q;
  assign bus.o_l_s1_vld    = l_vld_q;
  assign bus.o_l_e1        = e1_q;
  assign bus.o_l_e1_vld    = l_vld_q;
  assign bus.o_l_nleak     = nleak_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_key_len     = key_len_q;
  assign bus.o_key_len_vld = key_len_vld_q;
  assign bus.o_err         = err_q;
  assign bus.o_err_code    = err_code_q;

endmodule

// File: doc/key_len_seq_ctrl.md
Name: key_len_seq_ctrl

Overview:
- Top-level sequencer for the final key-length computation of the GHZ-QKD error-estimate core.
- On one start command it launches the s1 and e1 estimators and collects their results.
- It range-checks e1, then runs the alt_cal_l datapath (l = k*s1*(1-H(e1)) - nleak) with a correctly ordered start/valid handshake.
- It supervises the run with a timeout, then reports either the final key length or a coded error.

Parameters:
- E1_AMP, 24: fixed-point amplification of e1; valid e1 range is 1 .. 2^E1_AMP-1.
- TIMEOUT, 4096: maximum cycles allowed in CALC or WAIT_L before aborting.
- CNT_W, 13: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_start  in  1  run request pulse; accepted only in IDLE
- i_nleak  in  32  leaked-information bits; sampled on the accepted i_start
- o_s1_start  out  1  1-cycle start pulse to the s1 estimator
- o_e1_start  out  1  1-cycle start pulse to the e1 estimator
- i_s1  in  32  s1 result, unamplified
- i_s1_vld  in  1  s1 result valid
- i_e1  in  32  e1 result, scaled by 2^E1_AMP
- i_e1_vld  in  1  e1 result valid
- o_l_start  out  1  start pulse to the l datapath
- o_l_s1  out  32  latched s1 to the l datapath
- o_l_s1_vld  out  1  s1 valid to the l datapath
- o_l_e1  out  32  latched e1 to the l datapath
- o_l_e1_vld  out  1  e1 valid to the l datapath
- o_l_nleak  out  32  latched nleak to the l datapath
- i_l  in  32  l result, two's complement
- i_l_vld  in  1  l result valid
- i_l_error  in  1  datapath error flag
- o_busy  out  1  high from the accepted start until DONE/ERR exit
- o_key_len  out  32  final key length
- o_key_len_vld  out  1  1-cycle pulse when o_key_len is updated
- o_err  out  1  1-cycle error pulse
- o_err_code  out  2  error code: 0 none, 1 e1 out of range, 2 datapath error, 3 timeout

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE; latches, valid-seen flags and counter cleared.
- Reset mid-operation: abort immediately and return to IDLE next cycle. No pulses are emitted during or after reset.
- FSM states: IDLE, CALC, CHECK, LAUNCH, FEED, WAIT_L, DONE, ERR.
- IDLE:
  - i_start latches i_nleak, clears o_err_code, sets o_busy, goes to CALC.
  - o_s1_start and o_e1_start pulse together on the cycle after i_start.
  - i_start in any other state is ignored.
- CALC:
  - First i_s1_vld latches i_s1 and sets s1_seen; first i_e1_vld latches i_e1 and sets e1_seen.
  - The two valids may arrive in either order or in the same cycle; repeat valids are ignored.
  - When both seen flags are set, go to CHECK.
- CHECK (1 cycle):
  - If e1 == 0 or e1 >= 2^E1_AMP (includes bit31 set), go to ERR with code 1.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle): o_l_start = 1. o_l_s1/o_l_e1/o_l_nleak are held stable from here until IDLE.
- FEED (1 cycle): o_l_s1_vld = o_l_e1_vld = 1, then go to WAIT_L.
- WAIT_L:
  - On i_l_vld with i_l_error = 1, go to ERR with code 2.
  - Else on i_l_vld, o_key_len = i_l[31] ? 0 : i_l (negative l clamps to 0, not an error), then go to DONE.
  - i_l_vld in any other state is ignored.
- Timeout:
  - Counter clears on entry to CALC and on entry to WAIT_L, and increments every cycle in those states.
  - Counter == TIMEOUT-1 with no completing event goes to ERR with code 3.
  - A completing event in the same cycle as the timeout wins.
- DONE: o_key_len_vld pulses one cycle; o_busy drops; next state IDLE.
- ERR:
  - o_err pulses one cycle; o_busy drops; next state IDLE.
  - o_err_code holds until the next accepted i_start.
  - o_key_len keeps its previous value.
- Latency:
  - i_start at cycle 0 gives estimator starts at cycle 1.
  - Last of s1/e1 valid at cycle T gives CHECK at T+1, o_l_start at T+2, o_l_*_vld at T+3.
  - i_l_vld at cycle U gives o_key_len_vld at U+1.

Test Plan:
- Normal run: i_start with nleak=1000; s1=50000 at cycle 10; e1=0x0028F5C (~0.01*2^24) at cycle 12; i_l=0x0001_2345 -> o_l_start at 14, o_l_*_vld at 15, o_key_len=0x12345 and vld one cycle after i_l_vld, err_code 0.
- Result ordering: e1 and s1 valid in the same cycle, then a duplicate s1_vld with a different value -> first values are latched; launch 2 cycles later; a second i_start while busy is ignored.
- Range checks: e1=0 -> o_err pulse with code 1 and no o_l_start. e1=0x0100_0000 -> code 1. i_l=0xFFFF_FF00 -> o_key_len=0 with vld, no error.
- Datapath error: i_l_vld together with i_l_error=1 -> o_err, code 2, o_key_len unchanged.
- Timeout: e1 never valid -> o_err code 3 exactly TIMEOUT cycles after CALC entry. i_l_vld on the timeout cycle -> DONE, not ERR.
- Reset: rst asserted in WAIT_L -> all outputs 0 next cycle; a late i_l_vld is ignored; a fresh i_start runs normally.
